occupancy_lights: RTL

- Multi-zone successor to the single-zone automatic light controller.
- Each zone keeps a saturating occupancy count from enter/leave pulses and keeps its light on while occupied.
- After the last occupant leaves, the light holds for a programmable time before switching off.
- A per-zone force-on input overrides the light; all zones are independent and share one clock.

---
 rtl/occupancy_lights.sv | 107 ++++++++++
 1 files changed

// File: rtl/occupancy_lights.sv
// Multi-zone occupancy light controller. Each zone counts occupants and keeps
// its light on while occupied or forced, then holds it for HOLD_CYCLES cycles.
module occupancy_lights #(
    parameter int ZONES       = 4,
    parameter int CNT_W       = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int HOLD_W      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ZONES-1:0]       entering,
    input  logic [ZONES-1:0]       leaving,
    input  logic [ZONES-1:0]       force_on,
    output logic [ZONES-1:0]       light,
    output logic [ZONES-1:0]       occupied,
    output logic [ZONES*CNT_W-1:0] count_flat,
    output logic [ZONES-1:0]       overflow,
    output logic [2*ZONES-1:0]     state_dbg
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    for (genvar z = 0; z < ZONES; z++) begin : g_zone
        state_t            state_q, state_d;
        logic [CNT_W-1:0]  count_q, count_d;
        logic [HOLD_W-1:0] timer_q, timer_d;
        logic              ovf_q, ovf_d;
        logic              active;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_OFF;
                count_q <= '0;
                timer_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                timer_q <= timer_d;
                ovf_q   <= ovf_d;
            end
        end

        // The FSM looks at the post-update count so an enter lights the zone on the same edge.
        always_comb begin
            count_d = count_q;
            ovf_d   = ovf_q;
            state_d = state_q;
            timer_d = timer_q;

            if (entering[z] && !leaving[z]) begin
                if (count_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (leaving[z] && !entering[z]) begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end
            end

            active = (count_d != '0) || force_on[z];

            case (state_q)
                ST_OFF: begin
                    if (active) begin
                        state_d = ST_ON;
                    end
                end
                ST_ON: begin
                    if (!active) begin
                        state_d = ST_HOLD;
                        timer_d = HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (active) begin
                        state_d = ST_ON;
                    end else if (timer_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    timer_d = '0;
                end
            endcase
        end

        assign light[z]                   = (state_q != ST_OFF);
        assign occupied[z]                = (count_q != '0);
        assign count_flat[z*CNT_W +: CNT_W] = count_q;
        assign overflow[z]                = ovf_q;
        assign state_dbg[2*z +: 2]        = state_q;
    end

endmodule
